// File: rtl/interrupt_entry_sequencer_if.sv
// Memory port between the interrupt entry sequencer and the memory system.
//   master : sequencer side (drives request/write/address/data, receives ready/read data)
//   slave  : memory side
//   memRequest   access request
//   memWrite     1=write, 0=read; valid while memRequest=1
//   memAddress   access address
//   memData      write data
//   memReady     memory completes the current access this cycle
//   memReadData  read data; valid when memReady=1
interface interrupt_entry_sequencer_if #(
  parameter int unsigned ADDRESS_WIDTH = 32
);
  logic                     memRequest;
  logic                     memWrite;
  logic [ADDRESS_WIDTH-1:0] memAddress;
  logic [ADDRESS_WIDTH-1:0] memData;
  logic                     memReady;
  logic [ADDRESS_WIDTH-1:0] memReadData;

  modport master (
    output memRequest, memWrite, memAddress, memData,
    input  memReady, memReadData
  );

  modport slave (
    input  memRequest, memWrite, memAddress, memData,
    output memReady, memReadData
  );
endinterface

// File: rtl/interrupt_entry_sequencer.sv
// Interrupt entry sequencer: at an instruction boundary with a pending interrupt,
// stalls the core, pushes PC then PSW onto a full-descending stack, fetches the
// new PC from the vector address, then loads PC/SP, clears PSW.I and pulses a
// one-hot acknowledge for the serviced line.
// Ports:
//   clock, reset (async, active-low)
//   interruptPresent/interruptNumber/address : request from the interrupt handler
//   instructionDone, pc, psw, sp              : core state at the boundary
//   mem (master)                              : memory port (see interface file)
//   cpuStall, pcLoad/pcValue, spLoad/spValue, pswiClear : core control
//   resetInterrupt                            : one-hot acknowledge, 1 cycle
//   busError                                  : memory timeout abort strobe
// Optional feature: define INT_SEQ_TIMEOUT_EN to abort after TIMEOUT memReady wait
// cycles of any access; otherwise the sequencer waits indefinitely and busError=0.
module interrupt_entry_sequencer #(
  parameter int unsigned WIDTH         = 16,
  parameter int unsigned ADDRESS_WIDTH = 32,
  parameter int unsigned NUMBER_WIDTH  = 4,
  parameter int unsigned PSW_WIDTH     = 16,
  parameter int unsigned TIMEOUT       = 15
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     interruptPresent,
  input  logic [NUMBER_WIDTH-1:0]  interruptNumber,
  input  logic [ADDRESS_WIDTH-1:0] address,
  input  logic                     instructionDone,
  input  logic [ADDRESS_WIDTH-1:0] pc,
  input  logic [PSW_WIDTH-1:0]     psw,
  input  logic [ADDRESS_WIDTH-1:0] sp,
  interrupt_entry_sequencer_if.master mem,
  output logic                     cpuStall,
  output logic                     pcLoad,
  output logic                     spLoad,
  output logic [ADDRESS_WIDTH-1:0] pcValue,
  output logic [ADDRESS_WIDTH-1:0] spValue,
  output logic                     pswiClear,
  output logic [WIDTH-1:0]         resetInterrupt,
  output logic                     busError
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LATCH,
    S_PUSH_PC,
    S_PUSH_PSW,
    S_READ_VEC,
    S_COMMIT,
    S_BUS_ERR
  } state_t;

  state_t state, state_next;

  logic [NUMBER_WIDTH-1:0]  num_q;
  logic [ADDRESS_WIDTH-1:0] vector_q;
  logic [ADDRESS_WIDTH-1:0] pc_q;
  logic [PSW_WIDTH-1:0]     psw_q;
  logic [ADDRESS_WIDTH-1:0] sp_q;
  logic [ADDRESS_WIDTH-1:0] fetched_q;
  logic [WIDTH-1:0]         ack;
  logic                     timeout_hit;

`ifdef INT_SEQ_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] wait_cnt;

  // Restarts on every state change, so each access gets a fresh budget.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)                   wait_cnt <= '0;
    else if (state_next != state) wait_cnt <= '0;
    else if (mem.memRequest)      wait_cnt <= wait_cnt + CNT_W'(1);
  end

  assign timeout_hit = (wait_cnt == CNT_W'(TIMEOUT - 1)) && !mem.memReady;
  assign busError    = (state == S_BUS_ERR);
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT != 0);
  assign timeout_hit    = 1'b0;
  assign busError       = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_next;
  end

  // Request context is frozen in LATCH; later input changes are ignored.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      num_q     <= '0;
      vector_q  <= '0;
      pc_q      <= '0;
      psw_q     <= '0;
      sp_q      <= '0;
      fetched_q <= '0;
    end else begin
      if (state == S_LATCH) begin
        num_q    <= interruptNumber;
        vector_q <= address;
        pc_q     <= pc;
        psw_q    <= psw;
        sp_q     <= sp;
      end
      if (state == S_READ_VEC && mem.memReady) fetched_q <= mem.memReadData;
    end
  end

  // Numbers outside the line range decode to no acknowledge at all.
  always_comb begin
    ack = '0;
    for (int unsigned i = 0; i < WIDTH; i++) ack[i] = (32'(num_q) == i);
  end

  always_comb begin
    state_next     = state;
    cpuStall       = 1'b0;
    mem.memRequest = 1'b0;
    mem.memWrite   = 1'b0;
    mem.memAddress = '0;
    mem.memData    = '0;
    pcLoad         = 1'b0;
    spLoad         = 1'b0;
    pcValue        = '0;
    spValue        = '0;
    pswiClear      = 1'b0;
    resetInterrupt = '0;
    case (state)
      S_IDLE: begin
        if (instructionDone && interruptPresent) state_next = S_LATCH;
      end
      S_LATCH: begin
        cpuStall   = 1'b1;
        state_next = S_PUSH_PC;
      end
      S_PUSH_PC: begin
        cpuStall       = 1'b1;
        mem.memRequest = 1'b1;
        mem.memWrite   = 1'b1;
        mem.memAddress = sp_q - ADDRESS_WIDTH'(1);
        mem.memData    = pc_q;
        if (mem.memReady)  state_next = S_PUSH_PSW;
        else if (timeout_hit) state_next = S_BUS_ERR;
      end
      S_PUSH_PSW: begin
        cpuStall       = 1'b1;
        mem.memRequest = 1'b1;
        mem.memWrite   = 1'b1;
        mem.memAddress = sp_q - ADDRESS_WIDTH'(2);
        mem.memData    = ADDRESS_WIDTH'(psw_q);
        if (mem.memReady)  state_next = S_READ_VEC;
        else if (timeout_hit) state_next = S_BUS_ERR;
      end
      S_READ_VEC: begin
        cpuStall       = 1'b1;
        mem.memRequest = 1'b1;
        mem.memAddress = vector_q;
        if (mem.memReady)  state_next = S_COMMIT;
        else if (timeout_hit) state_next = S_BUS_ERR;
      end
      S_COMMIT: begin
        cpuStall       = 1'b1;
        pcLoad         = 1'b1;
        pcValue        = fetched_q;
        spLoad         = 1'b1;
        spValue        = sp_q - ADDRESS_WIDTH'(2);
        pswiClear      = 1'b1;
        resetInterrupt = ack;
        state_next     = S_IDLE;
      end
      S_BUS_ERR: state_next = S_IDLE;
      default:   state_next = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_interrupt_entry_sequencer.sv
// Directed bench for interrupt_entry_sequencer: a per-cycle vector table for
// zero-wait entries, plus hand-written wait-state, reset-abort and timeout sequences.
module tb_interrupt_entry_sequencer;
  localparam int unsigned AW = 32;
  localparam int unsigned NW = 4;
  localparam int unsigned W  = 16;
  localparam int unsigned PW = 16;

  logic          clock = 1'b0;
  logic          reset;
  logic          interruptPresent;
  logic [NW-1:0] interruptNumber;
  logic [AW-1:0] address;
  logic          instructionDone;
  logic [AW-1:0] pc;
  logic [PW-1:0] psw;
  logic [AW-1:0] sp;
  logic          cpuStall, pcLoad, spLoad, pswiClear, busError;
  logic [AW-1:0] pcValue, spValue;
  logic [W-1:0]  resetInterrupt;

  always #5 clock = ~clock;

  interrupt_entry_sequencer_if #(.ADDRESS_WIDTH(AW)) mem ();

  interrupt_entry_sequencer #(
    .WIDTH(W), .ADDRESS_WIDTH(AW), .NUMBER_WIDTH(NW), .PSW_WIDTH(PW), .TIMEOUT(15)
  ) u_dut (
    .clock(clock), .reset(reset),
    .interruptPresent(interruptPresent), .interruptNumber(interruptNumber),
    .address(address), .instructionDone(instructionDone),
    .pc(pc), .psw(psw), .sp(sp),
    .mem(mem),
    .cpuStall(cpuStall), .pcLoad(pcLoad), .spLoad(spLoad),
    .pcValue(pcValue), .spValue(spValue), .pswiClear(pswiClear),
    .resetInterrupt(resetInterrupt), .busError(busError)
  );

  typedef struct packed {
    logic          stall, req, wr;
    logic [AW-1:0] maddr, mdata;
    logic          pcl, spl;
    logic [AW-1:0] pcv, spv;
    logic          pswi;
    logic [W-1:0]  rint;
    logic          berr;
  } exp_t;

  typedef struct packed {
    logic          done, present;
    logic [NW-1:0] num;
    logic [AW-1:0] addr, pc;
    logic [PW-1:0] psw;
    logic [AW-1:0] sp;
    logic          ready;
    logic [AW-1:0] rdata;
    exp_t          e;
  } vec_t;

  vec_t vecs[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   pulses = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Values are only constrained while their qualifier is expected, unless strict.
  task automatic check_outs(input string tag, input exp_t e, input bit strict);
    chk({tag, ".cpuStall"},   64'(cpuStall),       64'(e.stall));
    chk({tag, ".memRequest"}, 64'(mem.memRequest), 64'(e.req));
    if (strict || e.req) begin
      chk({tag, ".memWrite"},   64'(mem.memWrite),   64'(e.wr));
      chk({tag, ".memAddress"}, 64'(mem.memAddress), 64'(e.maddr));
    end
    if (strict || (e.req && e.wr)) chk({tag, ".memData"}, 64'(mem.memData), 64'(e.mdata));
    chk({tag, ".pcLoad"}, 64'(pcLoad), 64'(e.pcl));
    chk({tag, ".spLoad"}, 64'(spLoad), 64'(e.spl));
    if (strict || e.pcl) chk({tag, ".pcValue"}, 64'(pcValue), 64'(e.pcv));
    if (strict || e.spl) chk({tag, ".spValue"}, 64'(spValue), 64'(e.spv));
    chk({tag, ".pswiClear"},      64'(pswiClear),      64'(e.pswi));
    chk({tag, ".resetInterrupt"}, 64'(resetInterrupt), 64'(e.rint));
    chk({tag, ".busError"},       64'(busError),       64'(e.berr));
  endtask

  function automatic exp_t e_idle();
    exp_t e;
    e = '0;
    return e;
  endfunction

  function automatic exp_t e_latch();
    exp_t e;
    e = '0;
    e.stall = 1'b1;
    return e;
  endfunction

  function automatic exp_t e_wr(input logic [AW-1:0] a, input logic [AW-1:0] d);
    exp_t e;
    e = '0;
    e.stall = 1'b1; e.req = 1'b1; e.wr = 1'b1; e.maddr = a; e.mdata = d;
    return e;
  endfunction

  function automatic exp_t e_rd(input logic [AW-1:0] a);
    exp_t e;
    e = '0;
    e.stall = 1'b1; e.req = 1'b1; e.maddr = a;
    return e;
  endfunction

  function automatic exp_t e_commit(input logic [AW-1:0] pcv, input logic [AW-1:0] spv,
                                    input logic [W-1:0] rint);
    exp_t e;
    e = '0;
    e.stall = 1'b1; e.pcl = 1'b1; e.spl = 1'b1; e.pswi = 1'b1;
    e.pcv = pcv; e.spv = spv; e.rint = rint;
    return e;
  endfunction

  function automatic vec_t mk(input logic done, input logic present, input logic [NW-1:0] num,
                              input logic [AW-1:0] addr, input logic [AW-1:0] pcv,
                              input logic [PW-1:0] pswv, input logic [AW-1:0] spv,
                              input logic ready, input logic [AW-1:0] rdata, input exp_t e);
    vec_t v;
    v.done = done; v.present = present; v.num = num; v.addr = addr; v.pc = pcv;
    v.psw = pswv; v.sp = spv; v.ready = ready; v.rdata = rdata; v.e = e;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    instructionDone  = v.done;
    interruptPresent = v.present;
    interruptNumber  = v.num;
    address          = v.addr;
    pc               = v.pc;
    psw              = v.psw;
    sp               = v.sp;
    mem.memReady     = v.ready;
    mem.memReadData  = v.rdata;
  endtask

  initial begin
    // Zero-wait entry: sp=0x100, pc=0x40, psw=0x8001, line 3, vector data 0x2000.
    vecs.push_back(mk(0, 1, 3, 'h80, 'h40, 'h8001, 'h100, 1, 'h2000, e_idle()));
    vecs.push_back(mk(1, 1, 3, 'h80, 'h40, 'h8001, 'h100, 1, 'h2000, e_idle()));
    vecs.push_back(mk(0, 1, 3, 'h80, 'h40, 'h8001, 'h100, 1, 'h2000, e_latch()));
    vecs.push_back(mk(0, 1, 3, 'h80, 'h40, 'h8001, 'h100, 1, 'h2000, e_wr('hFF, 'h40)));
    vecs.push_back(mk(0, 1, 3, 'h80, 'h40, 'h8001, 'h100, 1, 'h2000, e_wr('hFE, 'h8001)));
    vecs.push_back(mk(0, 1, 3, 'h80, 'h40, 'h8001, 'h100, 1, 'h2000, e_rd('h80)));
    vecs.push_back(mk(1, 1, 3, 'h80, 'h40, 'h8001, 'h100, 1, 'h2000, e_commit('h2000, 'hFE, 16'h0008)));
    vecs.push_back(mk(0, 0, 3, 'h80, 'h40, 'h8001, 'h100, 1, 'h2000, e_idle()));
    // Request drops and number/inputs change during PUSH_PC: latched values must win.
    vecs.push_back(mk(1, 1, 3, 'h8C, 'h1234, 'h0080, 'h200, 1, 'h3000, e_idle()));
    vecs.push_back(mk(0, 1, 3, 'h8C, 'h1234, 'h0080, 'h200, 1, 'h3000, e_latch()));
    vecs.push_back(mk(0, 0, 5, 'h94, 'h9999, 'hFFFF, 'h50, 1, 'h3000, e_wr('h1FF, 'h1234)));
    vecs.push_back(mk(0, 0, 5, 'h94, 'h9999, 'hFFFF, 'h50, 1, 'h3000, e_wr('h1FE, 'h0080)));
    vecs.push_back(mk(0, 0, 5, 'h94, 'h9999, 'hFFFF, 'h50, 1, 'h3000, e_rd('h8C)));
    vecs.push_back(mk(0, 0, 5, 'h94, 'h9999, 'hFFFF, 'h50, 1, 'h3000, e_commit('h3000, 'h1FE, 16'h0008)));
    vecs.push_back(mk(0, 0, 5, 'h94, 'h9999, 'hFFFF, 'h50, 1, 'h3000, e_idle()));
    // sp=0 wraps; top line 15 acknowledged.
    vecs.push_back(mk(1, 1, 15, 'h3C, 'h10, 'h0002, 'h0, 1, 'hABCD, e_idle()));
    vecs.push_back(mk(0, 1, 15, 'h3C, 'h10, 'h0002, 'h0, 1, 'hABCD, e_latch()));
    vecs.push_back(mk(0, 1, 15, 'h3C, 'h10, 'h0002, 'h0, 1, 'hABCD, e_wr('hFFFFFFFF, 'h10)));
    vecs.push_back(mk(0, 1, 15, 'h3C, 'h10, 'h0002, 'h0, 1, 'hABCD, e_wr('hFFFFFFFE, 'h2)));
    vecs.push_back(mk(0, 1, 15, 'h3C, 'h10, 'h0002, 'h0, 1, 'hABCD, e_rd('h3C)));
    vecs.push_back(mk(0, 0, 15, 'h3C, 'h10, 'h0002, 'h0, 1, 'hABCD, e_commit('hABCD, 'hFFFFFFFE, 16'h8000)));
    vecs.push_back(mk(0, 0, 15, 'h3C, 'h10, 'h0002, 'h0, 1, 'hABCD, e_idle()));

    reset = 1'b0;
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, e_idle()));
    repeat (2) @(posedge clock);
    @(negedge clock);
    check_outs("reset", e_idle(), 1'b1);
    reset = 1'b1;
    @(posedge clock); #1;

    foreach (vecs[i]) begin
      drive(vecs[i]);
      @(negedge clock);
      check_outs($sformatf("v%0d", i), vecs[i].e, 1'b0);
      @(posedge clock); #1;
    end

    // Three wait cycles in PUSH_PSW: outputs hold, COMMIT moves to cycle 8.
    drive(mk(1, 1, 3, 'h80, 'h40, 'h8001, 'h100, 1, 'h2000, e_idle()));
    @(posedge clock); #1;
    instructionDone = 1'b0;
    for (int c = 1; c <= 9; c++) begin
      mem.memReady = !(c >= 3 && c <= 5);
      @(negedge clock);
      chk($sformatf("t2.c%0d.cpuStall", c), 64'(cpuStall), 64'(c <= 8));
      chk($sformatf("t2.c%0d.pcLoad", c), 64'(pcLoad), 64'(c == 8));
      if (c >= 3 && c <= 6) begin
        chk($sformatf("t2.c%0d.memRequest", c), 64'(mem.memRequest), 64'(1));
        chk($sformatf("t2.c%0d.memWrite", c), 64'(mem.memWrite), 64'(1));
        chk($sformatf("t2.c%0d.memAddress", c), 64'(mem.memAddress), 64'('hFE));
        chk($sformatf("t2.c%0d.memData", c), 64'(mem.memData), 64'('h8001));
      end
      if (c == 7) chk("t2.c7.memAddress", 64'(mem.memAddress), 64'('h80));
      if (c == 8) begin
        chk("t2.c8.pcValue", 64'(pcValue), 64'('h2000));
        chk("t2.c8.spValue", 64'(spValue), 64'('hFE));
        chk("t2.c8.resetInterrupt", 64'(resetInterrupt), 64'(16'h0008));
      end
      @(posedge clock); #1;
    end

    // Reset asserted in READ_VEC aborts the entry immediately.
    drive(mk(1, 1, 3, 'h80, 'h40, 'h8001, 'h100, 1, 'h2000, e_idle()));
    @(posedge clock); #1;
    instructionDone = 1'b0;
    repeat (3) begin @(posedge clock); #1; end
    mem.memReady = 1'b0;
    @(negedge clock);
    chk("t5.read_vec.memRequest", 64'(mem.memRequest), 64'(1));
    chk("t5.read_vec.memWrite", 64'(mem.memWrite), 64'(0));
    #1 reset = 1'b0;
    #1 check_outs("t5.async", e_idle(), 1'b1);
    @(posedge clock); #1;
    mem.memReady = 1'b1;
    @(negedge clock);
    check_outs("t5.held", e_idle(), 1'b1);
    reset = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(posedge clock); #1;
      @(negedge clock);
      check_outs($sformatf("t5.after%0d", c), e_idle(), 1'b0);
    end
    @(posedge clock); #1;

`ifdef INT_SEQ_TIMEOUT_EN
    // memReady never arrives in PUSH_PC: one busError after 15 wait cycles, no commit.
    drive(mk(1, 1, 3, 'h80, 'h40, 'h8001, 'h100, 0, 'h2000, e_idle()));
    @(posedge clock); #1;
    instructionDone = 1'b0;
    for (int c = 1; c <= 24; c++) begin
      @(negedge clock);
      chk($sformatf("t6.c%0d.busError", c), 64'(busError), 64'(c == 17));
      chk($sformatf("t6.c%0d.pcLoad", c), 64'(pcLoad), 64'(0));
      if (busError) pulses++;
      if (c == 18) chk("t6.c18.cpuStall", 64'(cpuStall), 64'(0));
      @(posedge clock); #1;
    end
    chk("t6.pulses", 64'(pulses), 64'(1));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
